nios_sys_key_in: RTL and testbench

//  Avalon-MM slave input PIO for the nios_sys push-buttons/switches; the read-side counterpart of the output PIOs.

---
 rtl/nios_sys_pio_pkg.sv | 21 ++
 rtl/nios_sys_key_in_if.sv | 22 ++
 rtl/nios_sys_key_debounce.sv | 64 ++++++
 rtl/nios_sys_key_in.sv | 99 +++++++++
 tb/tb_nios_sys_key_in.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/nios_sys_pio_pkg.sv
// Shared constants and types for the nios_sys PIO blocks: Avalon word map,
// edge-type encodings and the debounce state enum.
package nios_sys_pio_pkg;

  localparam int unsigned ADDR_W = 2;
  localparam int unsigned DATA_W = 32;

  localparam logic [ADDR_W-1:0] ADDR_DATA    = 2'd0;
  localparam logic [ADDR_W-1:0] ADDR_IRQMASK = 2'd2;
  localparam logic [ADDR_W-1:0] ADDR_EDGECAP = 2'd3;

  localparam int unsigned EDGE_RISE = 0;
  localparam int unsigned EDGE_FALL = 1;
  localparam int unsigned EDGE_ANY  = 2;

  typedef enum logic {
    DB_STABLE = 1'b0,
    DB_COUNT  = 1'b1
  } db_state_e;

endpackage

// File: rtl/nios_sys_key_in_if.sv
// Avalon-MM slave bus for the nios_sys key input PIO, including its level IRQ.
interface nios_sys_key_in_if;
  import nios_sys_pio_pkg::*;

  logic [ADDR_W-1:0] address;
  logic              chipselect;
  logic              write_n;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;
  logic              irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );

endinterface

// File: rtl/nios_sys_key_debounce.sv
// Single-bit debounce: filt_out follows sync_in only after it has differed
// from filt_out for DB_CYCLES consecutive clocks.
module nios_sys_key_debounce
  import nios_sys_pio_pkg::*;
#(
  parameter int unsigned DB_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sync_in,
  output logic filt_out
);

  localparam int unsigned CNT_W = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  db_state_e        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             filt_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= DB_STABLE;
      cnt      <= '0;
      filt_out <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      filt_out <= filt_nxt;
    end
  end

  // Any return to the filtered level during COUNT restarts the stable-time window.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    filt_nxt  = filt_out;
    case (state)
      DB_STABLE: begin
        if (sync_in != filt_out) begin
          state_nxt = DB_COUNT;
          cnt_nxt   = '0;
        end
      end
      DB_COUNT: begin
        if (sync_in == filt_out) begin
          state_nxt = DB_STABLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = DB_STABLE;
          cnt_nxt   = '0;
          filt_nxt  = sync_in;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = DB_STABLE;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: rtl/nios_sys_key_in.sv
// nios_sys key/switch input PIO: 2-flop sync, optional debounce
// (NIOS_SYS_KEY_IN_DEBOUNCE_EN), edge capture with W1C and masked level IRQ.
module nios_sys_key_in
  import nios_sys_pio_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned EDGE_TYPE = 1,
  parameter int unsigned DB_CYCLES = 50000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [WIDTH-1:0]  in_port,
  nios_sys_key_in_if.slave  bus
);

  logic [WIDTH-1:0]  sync0, sync1;
  logic [WIDTH-1:0]  filt;
  logic [WIDTH-1:0]  d1;
  logic [WIDTH-1:0]  irqmask;
  logic [WIDTH-1:0]  edgecap;
  logic [WIDTH-1:0]  edge_c;
  logic [WIDTH-1:0]  clr_c;
  logic              wr_c, rd_c;
  logic [DATA_W-1:0] rd_mux_c;
  logic              unused_cfg;

  // Upper writedata bits have no register behind them.
  assign unused_cfg = ^{bus.writedata, DB_CYCLES};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync0 <= '0;
      sync1 <= '0;
    end else begin
      sync0 <= in_port;
      sync1 <= sync0;
    end
  end

`ifdef NIOS_SYS_KEY_IN_DEBOUNCE_EN
  for (genvar i = 0; i < WIDTH; i++) begin : g_db
    nios_sys_key_debounce #(
      .DB_CYCLES (DB_CYCLES)
    ) u_db (
      .clk      (clk),
      .reset_n  (reset_n),
      .sync_in  (sync1[i]),
      .filt_out (filt[i])
    );
  end
`else
  assign filt = sync1;
`endif

  always_comb begin
    edge_c = '0;
    case (EDGE_TYPE)
      EDGE_RISE: edge_c = filt & ~d1;
      EDGE_FALL: edge_c = ~filt & d1;
      default:   edge_c = filt ^ d1;
    endcase
  end

  assign wr_c  = bus.chipselect & ~bus.write_n;
  assign rd_c  = bus.chipselect & bus.write_n;
  assign clr_c = (wr_c && bus.address == ADDR_EDGECAP) ? bus.writedata[WIDTH-1:0] : '0;

  always_comb begin
    rd_mux_c = '0;
    case (bus.address)
      ADDR_DATA:    rd_mux_c = DATA_W'(filt);
      ADDR_IRQMASK: rd_mux_c = DATA_W'(irqmask);
      ADDR_EDGECAP: rd_mux_c = DATA_W'(edgecap);
      default:      rd_mux_c = '0;
    endcase
  end

  // A new edge in the same cycle as its W1C wins, so no edge is ever lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      d1           <= '0;
      edgecap      <= '0;
      irqmask      <= '0;
      bus.readdata <= '0;
      bus.irq      <= 1'b0;
    end else begin
      d1      <= filt;
      edgecap <= (edgecap & ~clr_c) | edge_c;
      if (wr_c && bus.address == ADDR_IRQMASK) begin
        irqmask <= bus.writedata[WIDTH-1:0];
      end
      if (rd_c) begin
        bus.readdata <= rd_mux_c;
      end
      bus.irq <= |(edgecap & irqmask);
    end
  end

endmodule

// File: tb/tb_nios_sys_key_in.sv
// Scoreboard bench for nios_sys_key_in: stimulus pushes expected read/irq values,
// a negedge monitor pops and compares them.
module tb_nios_sys_key_in;
  import nios_sys_pio_pkg::*;

  localparam int unsigned WIDTH = 4;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [WIDTH-1:0] in_port;

  nios_sys_key_in_if bus ();

  nios_sys_key_in #(
    .WIDTH     (WIDTH),
    .EDGE_TYPE (EDGE_FALL),
    .DB_CYCLES (8)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .in_port (in_port),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    bit          is_irq;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   rd_seen = 1'b0;

  always @(posedge clk) rd_seen <= bus.chipselect & bus.write_n;

  // Monitor: irq entries compare at the first negedge, read entries once a read was latched.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      if (exp_q[0].is_irq) begin
        e = exp_q.pop_front();
        n_tests++;
        if (bus.irq !== e.val[0]) begin
          n_fail++;
          $display("FAIL %s: irq=%0b expected %0b", e.name, bus.irq, e.val[0]);
        end
      end else if (rd_seen) begin
        e = exp_q.pop_front();
        n_tests++;
        if (bus.readdata !== e.val) begin
          n_fail++;
          $display("FAIL %s: readdata=%08h expected %08h", e.name, bus.readdata, e.val);
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] v, input string nm);
    bus.address    = a;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b1;
    exp_q.push_back('{name: nm, is_irq: 1'b0, val: v});
    tick();
    bus.chipselect = 1'b0;
  endtask

  // Optional irq check lands on the negedge right after the write edge.
  task automatic wr(input logic [1:0] a, input logic [31:0] d,
                    input bit chk = 1'b0, input bit irq_exp = 1'b0, input string nm = "");
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    if (chk) exp_q.push_back('{name: nm, is_irq: 1'b1, val: 32'(irq_exp)});
    tick();
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic chk_irq(input bit v, input string nm);
    exp_q.push_back('{name: nm, is_irq: 1'b1, val: 32'(v)});
    tick();
  endtask

  task automatic finish_run();
    tick();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  endtask

  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: run did not finish in time, expected finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    bus.address    = '0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;
    in_port        = 4'hF;
    reset_n        = 1'b0;
    ticks(3);
    rd(ADDR_EDGECAP, 32'h0, "rst_readdata");
    chk_irq(1'b0, "rst_irq");
    reset_n = 1'b1;

`ifdef NIOS_SYS_KEY_IN_DEBOUNCE_EN
    ticks(20);
    rd(ADDR_DATA, 32'hF, "db_settle_data");
    rd(ADDR_EDGECAP, 32'h0, "db_settle_cap");
    in_port = 4'hE;
    ticks(5);
    in_port = 4'hF;
    ticks(15);
    rd(ADDR_DATA, 32'hF, "db_glitch_data");
    rd(ADDR_EDGECAP, 32'h0, "db_glitch_cap");
    in_port = 4'hE;
    ticks(6);
    rd(ADDR_EDGECAP, 32'h0, "db_not_yet");
    ticks(10);
    rd(ADDR_EDGECAP, 32'h1, "db_long_cap");
    rd(ADDR_DATA, 32'hE, "db_long_data");
`else
    ticks(6);
    rd(ADDR_IRQMASK, 32'h0, "rst_irqmask");
    rd(ADDR_EDGECAP, 32'h0, "rst_edgecap");
    rd(ADDR_DATA, 32'hF, "data_idle");

    // Falling edge on bit0: capture visible to the read latched 4 edges later.
    in_port = 4'hE;
    rd(ADDR_EDGECAP, 32'h0, "lat_p1");
    rd(ADDR_EDGECAP, 32'h0, "lat_p2");
    rd(ADDR_EDGECAP, 32'h0, "lat_p3");
    rd(ADDR_EDGECAP, 32'h1, "lat_p4");
    rd(ADDR_DATA, 32'hE, "data_e");

    wr(ADDR_EDGECAP, 32'hF);
    wr(ADDR_IRQMASK, 32'h1);
    in_port = 4'hF;
    ticks(4);
    rd(ADDR_EDGECAP, 32'h0, "rise_ignored");
    in_port = 4'hE;
    ticks(2);
    chk_irq(1'b0, "irq_pre");
    chk_irq(1'b1, "irq_set");
    wr(ADDR_EDGECAP, 32'h1, 1'b1, 1'b1, "irq_hold");
    chk_irq(1'b0, "irq_clr");
    rd(ADDR_EDGECAP, 32'h0, "edgecap_clr");

    // Clear of bit1 in the very cycle its edge is captured.
    in_port = 4'hC;
    ticks(2);
    wr(ADDR_EDGECAP, 32'h2);
    rd(ADDR_EDGECAP, 32'h2, "w1c_race");
    chk_irq(1'b0, "race_masked");
    wr(ADDR_EDGECAP, 32'h2);
    rd(ADDR_EDGECAP, 32'h0, "race_cleared");

    in_port = 4'h4;
    ticks(4);
    rd(ADDR_EDGECAP, 32'h8, "bit3_cap");
    chk_irq(1'b0, "bit3_masked");
    wr(ADDR_IRQMASK, 32'h8);
    chk_irq(1'b1, "bit3_unmask");
    rd(ADDR_IRQMASK, 32'h8, "mask_rb");

    rd(2'd1, 32'h0, "addr1_zero");
    wr(ADDR_DATA, 32'hFFFF_FFFF);
    rd(ADDR_DATA, 32'h4, "data_wr_ignored");
    wr(ADDR_IRQMASK, 32'hFFFF_FFF0);
    rd(ADDR_IRQMASK, 32'h0, "mask_upper_ignored");
    ticks(1);
    chk_irq(1'b0, "mask_off");
    in_port = 4'hF;
    ticks(4);
    rd(ADDR_EDGECAP, 32'h8, "rise_no_cap");

    wr(ADDR_IRQMASK, 32'h8);
    reset_n = 1'b0;
    tick();
    rd(ADDR_EDGECAP, 32'h0, "midrst_rd");
    chk_irq(1'b0, "midrst_irq");
    reset_n = 1'b1;
    ticks(6);
    rd(ADDR_EDGECAP, 32'h0, "post_rst_edgecap");
    rd(ADDR_IRQMASK, 32'h0, "post_rst_mask");
    rd(ADDR_DATA, 32'hF, "post_rst_data");
    chk_irq(1'b0, "post_rst_irq");
`endif
    finish_run();
  end

endmodule
